// File: rtl/address_data_latches_pkg.sv
// Shared bus-side types and constants for the 6502 memory-side stage.
package cpu_bus_pkg;

  localparam logic [7:0] BUS_IDLE           = 8'hFF;
  localparam int         PHASE_HALF_DEFAULT = 6;

  typedef enum logic {
    CYC_READ  = 1'b0,
    CYC_WRITE = 1'b1
  } cycle_t;

  function automatic cycle_t rw_to_cycle(input logic rw);
    return rw ? CYC_READ : CYC_WRITE;
  endfunction

  // A non-driving source must present all ones on a wired-AND bus.
  function automatic logic [7:0] bus_drive(input logic en, input logic [7:0] val);
    return en ? val : BUS_IDLE;
  endfunction

endpackage

// File: rtl/address_data_latches_phase_sequencer.sv
// phi1/phi2 phase generator: one CPU cycle is 2*PHASE_HALF system clock ticks.
module phase_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int PHASE_HALF = PHASE_HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic phi1,
  output logic phi2,
  output logic phi1_end,
  output logic phi2_end
);

  localparam int CNT_W = $clog2(2 * PHASE_HALF);
  localparam logic [CNT_W-1:0] PHI1_LAST  = CNT_W'(PHASE_HALF - 1);
  localparam logic [CNT_W-1:0] PHI2_FIRST = CNT_W'(PHASE_HALF);
  localparam logic [CNT_W-1:0] PHI2_LAST  = CNT_W'(2 * PHASE_HALF - 1);
  // With a one-tick half cycle, count 0 is already the last phi1 tick.
  localparam logic RST_PHI1_END = (PHASE_HALF == 1) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             phi1_r;
  logic             phi1_end_r;
  logic             phi2_end_r;

  // Next count with wrap at the last phi2 tick.
  always_comb begin
    if (cnt_r == PHI2_LAST) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Phase flags are decoded from the next count so they are registered and aligned with cnt_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      phi1_r     <= 1'b1;
      phi1_end_r <= RST_PHI1_END;
      phi2_end_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      phi1_r     <= (cnt_next_s < PHI2_FIRST);
      phi1_end_r <= (cnt_next_s == PHI1_LAST);
      phi2_end_r <= (cnt_next_s == PHI2_LAST);
    end
  end

  assign phi1     = phi1_r;
  assign phi2     = !phi1_r;
  assign phi1_end = phi1_end_r;
  assign phi2_end = phi2_end_r;

endmodule

// File: rtl/address_data_latches.sv
// 6502 address/data latches (ABL/ABH/DOR/DL), strobes and RDY stall handling.
// Optional macro DL_OPEN_BUS_EN: DL keeps its value on reads without mem_rd_valid.
module address_data_latches
  import cpu_bus_pkg::*;
#(
  parameter int PHASE_HALF = PHASE_HALF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ADL_ABL,
  input  logic        ADH_ABH,
  input  logic        DB_DOR,
  input  logic        DL_DB,
  input  logic        DL_ADL,
  input  logic        DL_ADH,
  input  logic        R_W,
  input  logic        rdy,
  input  logic [7:0]  ADL_bus,
  input  logic [7:0]  ADH_bus,
  input  logic [7:0]  DB_bus,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rd_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  DB_out,
  output logic [7:0]  ADL_out,
  output logic [7:0]  ADH_out,
  output logic        phi1,
  output logic        phi2,
  output logic        cycle_end
);

  logic       phi1_end_s;
  logic       phi2_end_s;
  logic [7:0] abl_r;
  logic [7:0] abh_r;
  logic [7:0] dor_r;
  logic [7:0] dl_r;
  logic       rw_r;
  logic       stall_r;
  logic       mem_we_r;
  logic       mem_re_r;
  logic       cycle_end_r;
  cycle_t     cyc_s;
  logic       stall_hit_s;
  logic       stall_now_s;
  logic       advance_s;
  logic       load_s;
  logic       rw_next_s;
  logic       dl_take_s;

  phase_sequencer #(
    .PHASE_HALF (PHASE_HALF)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .phi1     (phi1),
    .phi2     (phi2),
    .phi1_end (phi1_end_s),
    .phi2_end (phi2_end_s)
  );

  assign cyc_s = rw_to_cycle(rw_r);

`ifndef DL_OPEN_BUS_EN
  logic unused_rd_valid_s;
  assign unused_rd_valid_s = mem_rd_valid;
`endif

  // Cycle completion, stall detection and the phi1_end load qualifier.
  always_comb begin
    stall_hit_s = 1'b0;
    case (cyc_s)
      CYC_READ:  stall_hit_s = !rdy;
      CYC_WRITE: stall_hit_s = 1'b0;
      default:   stall_hit_s = 1'b0;
    endcase

    if (phi2_end_s) begin
      stall_now_s = stall_hit_s;
      advance_s   = !stall_hit_s;
    end else begin
      stall_now_s = 1'b0;
      advance_s   = 1'b0;
    end

    // A stalled read replays its address phase, so phi1 loads wait for the release.
    load_s = phi1_end_s && !stall_r;
    if (load_s) begin
      rw_next_s = R_W;
    end else begin
      rw_next_s = rw_r;
    end

    if (advance_s && (cyc_s == CYC_READ)) begin
`ifdef DL_OPEN_BUS_EN
      dl_take_s = mem_rd_valid;
`else
      dl_take_s = 1'b1;
`endif
    end else begin
      dl_take_s = 1'b0;
    end
  end

  // Address/data latches, direction, stall flag and phi2 strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      abl_r       <= 8'h00;
      abh_r       <= 8'h00;
      dor_r       <= 8'h00;
      dl_r        <= 8'h00;
      rw_r        <= 1'b1;
      stall_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      cycle_end_r <= 1'b0;
    end else begin
      if (load_s) begin
        if (ADL_ABL) begin
          abl_r <= ADL_bus;
        end
        if (ADH_ABH) begin
          abh_r <= ADH_bus;
        end
        if (DB_DOR) begin
          dor_r <= DB_bus;
        end
      end
      rw_r <= rw_next_s;

      // Strobes cover exactly the phi2 ticks: set entering phi2, cleared leaving it.
      if (phi1_end_s) begin
        mem_re_r <= rw_next_s;
        mem_we_r <= !rw_next_s;
      end else if (phi2_end_s) begin
        mem_re_r <= 1'b0;
        mem_we_r <= 1'b0;
      end

      if (phi2_end_s) begin
        stall_r <= stall_now_s;
      end
      if (dl_take_s) begin
        dl_r <= mem_rdata;
      end
      cycle_end_r <= advance_s;
    end
  end

  assign mem_addr  = {abh_r, abl_r};
  assign mem_wdata = dor_r;
  assign mem_we    = mem_we_r;
  assign mem_re    = mem_re_r;
  assign cycle_end = cycle_end_r;

  assign DB_out  = bus_drive(DL_DB, dl_r);
  assign ADL_out = bus_drive(DL_ADL, dl_r);
  assign ADH_out = bus_drive(DL_ADH, dl_r);

endmodule

// File: tb/tb_address_data_latches.sv
// Scenario bench for address_data_latches (PHASE_HALF=6 main instance, PHASE_HALF=1 companion).
module tb_address_data_latches;

  logic        clk = 1'b0;
  logic        rst;
  logic        ADL_ABL, ADH_ABH, DB_DOR, DL_DB, DL_ADL, DL_ADH, R_W, rdy, mem_rd_valid;
  logic [7:0]  ADL_bus, ADH_bus, DB_bus, mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, DB_out, ADL_out, ADH_out;
  logic        mem_we, mem_re, phi1, phi2, cycle_end;

  logic [15:0] h1_addr;
  logic [7:0]  h1_wdata, h1_db, h1_adl, h1_adh;
  logic        h1_we, h1_re, h1_phi1, h1_phi2, h1_ce;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  logic [11:0] rec_p1, rec_re, rec_we, rec_ce, rec_h1_p1, rec_h1_ce, rec_h1_re;
  logic [15:0] rec_addr5, rec_addr6;
  logic [7:0]  rec_wdata6;
  logic        rec_ce_next;

  always #5 clk = ~clk;

  address_data_latches #(.PHASE_HALF(6)) dut (
    .clk(clk), .rst(rst), .ADL_ABL(ADL_ABL), .ADH_ABH(ADH_ABH), .DB_DOR(DB_DOR),
    .DL_DB(DL_DB), .DL_ADL(DL_ADL), .DL_ADH(DL_ADH), .R_W(R_W), .rdy(rdy),
    .ADL_bus(ADL_bus), .ADH_bus(ADH_bus), .DB_bus(DB_bus), .mem_rdata(mem_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .DB_out(DB_out), .ADL_out(ADL_out),
    .ADH_out(ADH_out), .phi1(phi1), .phi2(phi2), .cycle_end(cycle_end)
  );

  address_data_latches #(.PHASE_HALF(1)) dut_h1 (
    .clk(clk), .rst(rst), .ADL_ABL(ADL_ABL), .ADH_ABH(ADH_ABH), .DB_DOR(DB_DOR),
    .DL_DB(DL_DB), .DL_ADL(DL_ADL), .DL_ADH(DL_ADH), .R_W(R_W), .rdy(rdy),
    .ADL_bus(ADL_bus), .ADH_bus(ADH_bus), .DB_bus(DB_bus), .mem_rdata(mem_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_addr(h1_addr), .mem_wdata(h1_wdata),
    .mem_we(h1_we), .mem_re(h1_re), .DB_out(h1_db), .ADL_out(h1_adl),
    .ADH_out(h1_adh), .phi1(h1_phi1), .phi2(h1_phi2), .cycle_end(h1_ce)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observe one full CPU cycle from tick 0; leaves the bench at tick 0 of the next cycle.
  task automatic run_cycle();
    for (int t = 0; t < 12; t++) begin
      rec_p1[t]    = phi1;
      rec_re[t]    = mem_re;
      rec_we[t]    = mem_we;
      rec_ce[t]    = cycle_end;
      rec_h1_p1[t] = h1_phi1;
      rec_h1_ce[t] = h1_ce;
      rec_h1_re[t] = h1_re;
      if (t == 5) rec_addr5 = mem_addr;
      if (t == 6) begin
        rec_addr6  = mem_addr;
        rec_wdata6 = mem_wdata;
      end
      step();
    end
    rec_ce_next = cycle_end;
  endtask

  task automatic test_reset();
    rst = 1'b1; DL_DB = 1'b1; DL_ADL = 1'b0;
    step(); step();
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_dor: got %h want 00", mem_wdata); end
    n_checks++; if ({mem_we, mem_re, cycle_end} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {mem_we, mem_re, cycle_end}); end
    n_checks++; if (DB_out !== 8'h00) begin n_fail++; $display("FAIL reset_dl: got %h want 00", DB_out); end
    n_checks++; if (ADL_out !== 8'hFF) begin n_fail++; $display("FAIL reset_adl_idle: got %h want ff", ADL_out); end
    n_checks++; if ({phi1, phi2} !== 2'b10) begin n_fail++; $display("FAIL reset_phase: got %b want 10", {phi1, phi2}); end
    rst = 1'b0; DL_DB = 1'b0;
  endtask

  task automatic test_free_run();
    R_W = 1'b1; rdy = 1'b1;
    exp_q.push_back(16'h003F); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    run_cycle();
    exp = exp_q.pop_front();
    n_checks++; if ({4'h0, rec_p1} !== exp) begin n_fail++; $display("FAIL free_run_phi1: got %h want %h", rec_p1, exp); end
    exp = exp_q.pop_front();
    n_checks++; if ({4'h0, rec_ce} !== exp) begin n_fail++; $display("FAIL free_run_ce_first: got %h want %h", rec_ce, exp); end
    n_checks++; if (rec_ce_next !== 1'b1) begin n_fail++; $display("FAIL free_run_ce_pulse: got %b want 1", rec_ce_next); end
    n_checks++; if (rec_addr6 !== 16'h0000) begin n_fail++; $display("FAIL free_run_addr: got %h want 0000", rec_addr6); end
    n_checks++; if (rec_h1_p1 !== 12'h555) begin n_fail++; $display("FAIL half1_phi1: got %h want 555", rec_h1_p1); end
    n_checks++; if (rec_h1_ce !== 12'h554) begin n_fail++; $display("FAIL half1_ce: got %h want 554", rec_h1_ce); end
    n_checks++; if (rec_h1_re !== 12'hAAA) begin n_fail++; $display("FAIL half1_re: got %h want aaa", rec_h1_re); end
    run_cycle();
    exp = exp_q.pop_front();
    n_checks++; if ({4'h0, rec_ce} !== exp) begin n_fail++; $display("FAIL free_run_ce_period: got %h want %h", rec_ce, exp); end
  endtask

  task automatic test_read();
    ADL_bus = 8'h34; ADH_bus = 8'h12; ADL_ABL = 1'b1; ADH_ABH = 1'b1;
    R_W = 1'b1; rdy = 1'b1; mem_rdata = 8'hA9; mem_rd_valid = 1'b1;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h00A9);
    run_cycle();
    n_checks++; if (rec_addr5 !== 16'h0000) begin n_fail++; $display("FAIL read_addr_early: got %h want 0000", rec_addr5); end
    exp = exp_q.pop_front();
    n_checks++; if (rec_addr6 !== exp) begin n_fail++; $display("FAIL read_addr: got %h want %h", rec_addr6, exp); end
    n_checks++; if ({rec_re, rec_we} !== {12'hFC0, 12'h000}) begin n_fail++; $display("FAIL read_strobes: re %h we %h want fc0 000", rec_re, rec_we); end
    DL_DB = 1'b1; #1;
    exp = exp_q.pop_front();
    n_checks++; if ({8'h00, DB_out} !== exp) begin n_fail++; $display("FAIL read_dl: got %h want %h", DB_out, exp); end
    n_checks++; if ({ADL_out, ADH_out} !== 16'hFFFF) begin n_fail++; $display("FAIL read_idle_busses: got %h want ffff", {ADL_out, ADH_out}); end
    DL_ADH = 1'b1; #1;
    n_checks++; if ({DB_out, ADH_out} !== 16'hA9A9) begin n_fail++; $display("FAIL read_multi_drive: got %h want a9a9", {DB_out, ADH_out}); end
    DL_ADH = 1'b0; ADL_ABL = 1'b0; ADH_ABH = 1'b0;
  endtask

  task automatic test_write();
    DB_bus = 8'h5C; DB_DOR = 1'b1; R_W = 1'b0; rdy = 1'b0; mem_rdata = 8'h11;
    exp_q.push_back(16'h005C);
    run_cycle();
    exp = exp_q.pop_front();
    n_checks++; if ({8'h00, rec_wdata6} !== exp) begin n_fail++; $display("FAIL write_dor: got %h want %h", rec_wdata6, exp); end
    n_checks++; if ({rec_we, rec_re} !== {12'hFC0, 12'h000}) begin n_fail++; $display("FAIL write_strobes: we %h re %h want fc0 000", rec_we, rec_re); end
    n_checks++; if (rec_ce_next !== 1'b1) begin n_fail++; $display("FAIL write_ignores_rdy: got %b want 1", rec_ce_next); end
    n_checks++; if (rec_addr6 !== 16'h1234) begin n_fail++; $display("FAIL write_addr_hold: got %h want 1234", rec_addr6); end
    n_checks++; if (DB_out !== 8'hA9) begin n_fail++; $display("FAIL write_dl_hold: got %h want a9", DB_out); end
    DB_DOR = 1'b0;
  endtask

  task automatic test_stall();
    R_W = 1'b1; rdy = 1'b0; ADL_bus = 8'h56; ADH_bus = 8'h78;
    ADL_ABL = 1'b1; ADH_ABH = 1'b1; mem_rdata = 8'h22;
    exp_q.push_back(16'h7856);
    run_cycle();
    exp = exp_q.pop_front();
    n_checks++; if (rec_addr6 !== exp) begin n_fail++; $display("FAIL stall_addr_load: got %h want %h", rec_addr6, exp); end
    n_checks++; if (rec_ce_next !== 1'b0) begin n_fail++; $display("FAIL stall1_no_ce: got %b want 0", rec_ce_next); end
    n_checks++; if (DB_out !== 8'hA9) begin n_fail++; $display("FAIL stall_dl_hold: got %h want a9", DB_out); end
    ADL_bus = 8'hFF;
    run_cycle();
    n_checks++; if (rec_addr6 !== 16'h7856) begin n_fail++; $display("FAIL stall_addr_stable: got %h want 7856", rec_addr6); end
    n_checks++; if ({rec_ce, rec_ce_next} !== 13'h0000) begin n_fail++; $display("FAIL stall2_no_ce: got %h want 0000", {rec_ce, rec_ce_next}); end
    n_checks++; if (rec_re !== 12'hFC0) begin n_fail++; $display("FAIL stall_re: got %h want fc0", rec_re); end
    rdy = 1'b1; mem_rdata = 8'h77;
    exp_q.push_back(16'h0077);
    run_cycle();
    n_checks++; if ({rec_addr6, rec_ce_next} !== {16'h7856, 1'b1}) begin n_fail++; $display("FAIL stall_release: addr %h ce %b want 7856 1", rec_addr6, rec_ce_next); end
    exp = exp_q.pop_front();
    n_checks++; if ({8'h00, DB_out} !== exp) begin n_fail++; $display("FAIL stall_release_dl: got %h want %h", DB_out, exp); end
    run_cycle();
    n_checks++; if (rec_addr6 !== 16'h78FF) begin n_fail++; $display("FAIL stall_load_resume: got %h want 78ff", rec_addr6); end
    ADL_ABL = 1'b0; ADH_ABH = 1'b0;
  endtask

  task automatic test_open_bus();
    R_W = 1'b1; rdy = 1'b1; mem_rdata = 8'h40; mem_rd_valid = 1'b1;
    run_cycle();
    n_checks++; if (DB_out !== 8'h40) begin n_fail++; $display("FAIL open_bus_setup: got %h want 40", DB_out); end
    mem_rd_valid = 1'b0; mem_rdata = 8'h00;
`ifdef DL_OPEN_BUS_EN
    exp_q.push_back(16'h0040);
`else
    exp_q.push_back(16'h0000);
`endif
    run_cycle();
    n_checks++; if (rec_ce_next !== 1'b1) begin n_fail++; $display("FAIL open_bus_ce: got %b want 1", rec_ce_next); end
    exp = exp_q.pop_front();
    n_checks++; if ({8'h00, DB_out} !== exp) begin n_fail++; $display("FAIL open_bus_dl: got %h want %h", DB_out, exp); end
    mem_rd_valid = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  dl_model;
    dl_model = 8'h00;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); d = 8'($urandom);
      ADL_bus = a[7:0]; ADH_bus = a[15:8]; ADL_ABL = 1'b1; ADH_ABH = 1'b1;
      R_W = i[0]; rdy = 1'b1; DB_bus = d; DB_DOR = !i[0]; mem_rdata = ~d;
      exp_q.push_back(a);
      if (i[0]) dl_model = ~d;
      exp_q.push_back({8'h00, dl_model});
      run_cycle();
      exp = exp_q.pop_front();
      n_checks++; if (rec_addr6 !== exp) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, rec_addr6, exp); end
      if (!i[0]) begin
        n_checks++; if ({rec_wdata6, rec_we} !== {d, 12'hFC0}) begin n_fail++; $display("FAIL b2b_write[%0d]: data %h we %h want %h fc0", i, rec_wdata6, rec_we, d); end
      end
      exp = exp_q.pop_front();
      n_checks++; if ({8'h00, DB_out} !== exp) begin n_fail++; $display("FAIL b2b_dl[%0d]: got %h want %h", i, DB_out, exp); end
    end
    ADL_ABL = 1'b0; ADH_ABH = 1'b0; DB_DOR = 1'b0; R_W = 1'b1;
  endtask

  task automatic test_reset_mid_cycle();
    DB_bus = 8'h3C; DB_DOR = 1'b1; R_W = 1'b0; rdy = 1'b1;
    repeat (8) step();
    n_checks++; if ({mem_we, mem_wdata} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL midrst_before: we %b dor %h want 1 3c", mem_we, mem_wdata); end
    rst = 1'b1;
    step();
    n_checks++; if ({mem_we, mem_re, cycle_end} !== 3'b000) begin n_fail++; $display("FAIL midrst_strobes: got %b want 000", {mem_we, mem_re, cycle_end}); end
    n_checks++; if ({mem_wdata, DB_out} !== 16'h0000) begin n_fail++; $display("FAIL midrst_regs: got %h want 0000", {mem_wdata, DB_out}); end
    rst = 1'b0; DB_DOR = 1'b0; R_W = 1'b1;
    repeat (5) step();
    n_checks++; if (phi1 !== 1'b1) begin n_fail++; $display("FAIL midrst_tick5_phi1: got %b want 1", phi1); end
    step();
    n_checks++; if ({phi1, mem_re} !== 2'b01) begin n_fail++; $display("FAIL midrst_tick6: got %b want 01", {phi1, mem_re}); end
    repeat (6) step();
    n_checks++; if (cycle_end !== 1'b1) begin n_fail++; $display("FAIL midrst_cycle_end: got %b want 1", cycle_end); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ADL_ABL = 1'b0; ADH_ABH = 1'b0; DB_DOR = 1'b0;
    DL_DB = 1'b0; DL_ADL = 1'b0; DL_ADH = 1'b0;
    R_W = 1'b1; rdy = 1'b1; mem_rd_valid = 1'b1;
    ADL_bus = 8'h00; ADH_bus = 8'h00; DB_bus = 8'h00; mem_rdata = 8'h00;
    test_reset();
    test_free_run();
    test_read();
    test_write();
    test_stall();
    test_open_bus();
    test_back_to_back();
    test_reset_mid_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/address_data_latches.md
Name: address_data_latches

Overview:
- Memory-side stage of the 6502 core, directly downstream of the internal bus combiner.
- Consumes the resolved ADL/ADH/DB internal busses and latches ABL/ABH (address out) and DOR (data out).
- Captures external read data into DL and drives DL back onto DB/ADL/ADH for the bus combiner.
- Generates the phi1/phi2 phase timing from the single system clock, and applies RDY stalls.

Parameters:
- PHASE_HALF, 6, clk ticks per CPU half-cycle; one CPU cycle = 2*PHASE_HALF ticks (NES master/12). Legal range: >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ADL_ABL  in  1  load ABL from ADL_bus at phi1 end
- ADH_ABH  in  1  load ABH from ADH_bus at phi1 end
- DB_DOR  in  1  load DOR from DB_bus at phi1 end
- DL_DB / DL_ADL / DL_ADH  in  1 each  drive DL onto DB_out / ADL_out / ADH_out
- R_W  in  1  1=read cycle, 0=write cycle; sampled at phi1 end
- rdy  in  1  6502 RDY; low stalls read cycles
- ADL_bus, ADH_bus, DB_bus  in  8 each  resolved internal busses from the bus combiner
- mem_rdata  in  8  external read data
- mem_rd_valid  in  1  external read data valid (used only with the optional feature)
- mem_addr  out  16  {ABH,ABL}
- mem_wdata  out  8  DOR
- mem_we, mem_re  out  1 each  write/read strobe, asserted for all of phi2
- DB_out, ADL_out, ADH_out  out  8 each  DL contribution to wired-AND busses; 8'hFF when not driven
- phi1, phi2  out  1 each  phase indicators
- cycle_end  out  1  one-tick pulse at the end of each non-stalled CPU cycle

Behaviour:
- Reset (synchronous, active-high; clk/rst fixed as stated):
  - phase_cnt=0, ABL=ABH=8'h00, DL=8'h00, DOR=8'h00, rw_q=1.
  - mem_we=mem_re=cycle_end=0.
  - Reset mid-cycle aborts the cycle; no strobe or latch occurs in the reset tick.
- Phase counter:
  - Width $clog2(2*PHASE_HALF); counts 0..2*PHASE_HALF-1, then wraps to 0.
  - phi1 = cnt<PHASE_HALF; phi2 = !phi1.
  - phi1_end = (cnt==PHASE_HALF-1); phi2_end = (cnt==2*PHASE_HALF-1).
- At phi1_end (registered, visible the next tick):
  - ABL<=ADL_bus if ADL_ABL; ABH<=ADH_bus if ADH_ABH.
  - DOR<=DB_bus if DB_DOR.
  - rw_q<=R_W.
  - Unselected registers hold their values.
- During phi2:
  - mem_re=rw_q; mem_we=!rw_q.
  - Both strobes are registered, so they rise on the first phi2 tick and fall on the tick after phi2_end.
- At phi2_end:
  - Read (rw_q=1) and rdy=1: DL<=mem_rdata; cycle_end pulses for 1 tick.
  - Read and rdy=0: stall. DL, ABL/ABH and DOR hold; no cycle_end pulse. The phase counter keeps running, and phi1_end loads are suppressed until a non-stalled phi2_end.
  - Write (rw_q=0): rdy is ignored; cycle_end pulses.
- Bus outputs are combinational: DB_out = DL_DB ? DL : 8'hFF (ADL_out/ADH_out likewise). Multiple drive enables are legal.
- Simultaneous load enables are independent; the same-tick load of ABL and ABH is atomic in mem_addr.
- PHASE_HALF=1: phi1_end and phi2_end are consecutive ticks, and all rules above still hold.

Optional Feature:
- Macro: DL_OPEN_BUS_EN.
- Defined: at a non-stalled read phi2_end with mem_rd_valid=0, DL holds its previous value (NES open bus). cycle_end still pulses.
- Undefined: mem_rd_valid is ignored and DL always captures mem_rdata.

Decomposition:
- Package cpu_bus_pkg:
  - BUS_IDLE=8'hFF.
  - PHASE_HALF_DEFAULT=6.
  - Enum cycle_t {CYC_READ, CYC_WRITE}.
- Sub-module phase_sequencer (parameter PHASE_HALF; outputs phi1, phi2, phi1_end, phi2_end). The latches stay in the top.

Test Plan:
- Reset, then PHASE_HALF=6 free-run: phi1 high for ticks 0-5 and phi2 for ticks 6-11; cycle_end pulses every 12 ticks; mem_addr=16'h0000.
- Read: ADL_bus=8'h34, ADH_bus=8'h12, ADL_ABL=ADH_ABH=1, R_W=1, mem_rdata=8'hA9 -> mem_addr=16'h1234 from tick 6; mem_re high ticks 6-11; DL=8'hA9; DL_DB=1 gives DB_out=8'hA9 while ADL_out=8'hFF.
- Write: DB_bus=8'h5C, DB_DOR=1, R_W=0, rdy=0 -> mem_wdata=8'h5C; mem_we high for phi2; cycle_end pulses despite rdy=0.
- Stall: read with rdy=0 for 2 cycles, then rdy=1, mem_rdata=8'h77 -> no cycle_end for 2 cycles; mem_addr stable even with new ADL_bus=8'hFF and ADL_ABL=1; DL=8'h77 after release.
- Reset asserted at tick 8 of a write -> mem_we=0 next tick; DOR=8'h00; phase_cnt=0.
- DL_OPEN_BUS_EN: DL=8'h40, then read with mem_rd_valid=0 and mem_rdata=8'h00 -> DL stays 8'h40. Without the macro -> DL=8'h00.
